// File: rtl/pt2262_frame_encoder.sv
// PT2262-compatible encoder: serialises 8 address trits and 4 data bits into
// 512-alpha frames (12 bit symbols plus one sync symbol) on DOUT.
module pt2262_frame_encoder #(
    parameter int unsigned CLKS_PER_ALPHA = 1,
    parameter int unsigned MIN_FRAMES     = 4
) (
    input  logic        INPUT_CLK,
    input  logic        RST,
    input  logic        TE_N,
    input  logic [15:0] ADDR,
    input  logic [3:0]  DATA,
    output logic        DOUT,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    localparam logic [7:0] PRE_LAST = 8'(CLKS_PER_ALPHA - 1);
    localparam logic [3:0] MIN_F    = 4'(MIN_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIT  = 2'd1,
        S_SYNC = 2'd2
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [19:0] word;
    logic [19:0] nxt_word;
    logic [3:0]  bit_idx;
    logic [3:0]  nxt_bit;
    logic [6:0]  alpha_cnt;
    logic [6:0]  nxt_alpha;
    logic [7:0]  pre_cnt;
    logic [7:0]  nxt_pre;
    logic [3:0]  frames_sent;
    logic [3:0]  frames_inc;
    logic        pre_wrap;
    logic        bit_end;
    logic        sync_end;
    logic        keep_going;
    logic        nxt_dout;
    logic        nxt_done;

    // Trit code of symbol idx: 00 = 0, 01 = 1, 1x = F; data bits are 0/1 trits.
    function automatic logic [1:0] trit_of(input logic [19:0] w, input logic [3:0] idx);
        logic [4:0] base;
        if (idx < 4'd8) begin
            base = {1'b0, idx[2:0], 1'b0} + 5'd4;
            return w[base +: 2];
        end
        return {1'b0, w[idx[1:0]]};
    endfunction

    // Each half-symbol is 16 alpha: 0 = H4 L12 H4 L12, 1 = H12 L4 H12 L4, F = H4 L12 H12 L4.
    function automatic logic bit_level(input logic [1:0] trit, input logic [4:0] a);
        logic [4:0] b;
        b = a - 5'd16;
        if (a < 5'd16)
            return (trit == 2'b01) ? (a < 5'd12) : (a < 5'd4);
        return (trit == 2'b00) ? (b < 5'd4) : (b < 5'd12);
    endfunction

    assign pre_wrap   = (pre_cnt == PRE_LAST);
    assign bit_end    = (state == S_BIT) && pre_wrap && (alpha_cnt[4:0] == 5'd31);
    assign sync_end   = (state == S_SYNC) && pre_wrap && (alpha_cnt == 7'd127);
    assign frames_inc = (frames_sent == 4'd15) ? 4'd15 : frames_sent + 4'd1;
    assign keep_going = !TE_N || (frames_inc < MIN_F);

    // Position of the next output cycle; DOUT and FRAME_DONE are registered from it.
    always_comb begin
        nxt_state = state;
        nxt_word  = word;
        nxt_bit   = bit_idx;
        nxt_pre   = pre_wrap ? 8'd0 : pre_cnt + 8'd1;
        nxt_alpha = pre_wrap ? alpha_cnt + 7'd1 : alpha_cnt;
        case (state)
            S_IDLE: begin
                nxt_pre   = 8'd0;
                nxt_alpha = 7'd0;
                nxt_bit   = 4'd0;
                if (!TE_N) begin
                    nxt_state = S_BIT;
                    nxt_word  = {ADDR, DATA};
                end
            end
            S_BIT: begin
                if (bit_end) begin
                    nxt_alpha = 7'd0;
                    if (bit_idx == 4'd11)
                        nxt_state = S_SYNC;
                    else
                        nxt_bit = bit_idx + 4'd1;
                end
            end
            S_SYNC: begin
                if (sync_end) begin
                    nxt_alpha = 7'd0;
                    nxt_bit   = 4'd0;
                    if (keep_going) begin
                        nxt_state = S_BIT;
                        nxt_word  = {ADDR, DATA};
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase

        case (nxt_state)
            S_BIT:   nxt_dout = bit_level(trit_of(nxt_word, nxt_bit), nxt_alpha[4:0]);
            S_SYNC:  nxt_dout = (nxt_alpha < 7'd4);
            default: nxt_dout = 1'b0;
        endcase
        nxt_done = (nxt_state == S_SYNC) && (nxt_alpha == 7'd127) && (nxt_pre == PRE_LAST);
    end

    // State, counters and registered outputs; reset wins even mid-frame.
    always_ff @(posedge INPUT_CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            word        <= 20'd0;
            bit_idx     <= 4'd0;
            alpha_cnt   <= 7'd0;
            pre_cnt     <= 8'd0;
            frames_sent <= 4'd0;
            DOUT        <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
        end else begin
            state      <= nxt_state;
            word       <= nxt_word;
            bit_idx    <= nxt_bit;
            alpha_cnt  <= nxt_alpha;
            pre_cnt    <= nxt_pre;
            DOUT       <= nxt_dout;
            BUSY       <= (nxt_state != S_IDLE);
            FRAME_DONE <= nxt_done;
            if (state == S_IDLE)
                frames_sent <= 4'd0;
            else if (sync_end)
                frames_sent <= frames_inc;
        end
    end

endmodule

// File: tb/tb_pt2262_frame_encoder.sv
// Directed bench for pt2262_frame_encoder: alpha=1 instance for waveform and
// frame-count tests, alpha=3 / single-frame instance for the prescaler test.
module tb_pt2262_frame_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        te_n_a;
    logic        te_n_b;
    logic [15:0] addr;
    logic [3:0]  data;
    logic        dout_a, busy_a, done_a;
    logic        dout_b, busy_b, done_b;
    int          checks;
    int          errors;

    pt2262_frame_encoder #(.CLKS_PER_ALPHA(1), .MIN_FRAMES(4)) dut_a (
        .INPUT_CLK (clk),
        .RST       (rst_n),
        .TE_N      (te_n_a),
        .ADDR      (addr),
        .DATA      (data),
        .DOUT      (dout_a),
        .BUSY      (busy_a),
        .FRAME_DONE(done_a)
    );

    pt2262_frame_encoder #(.CLKS_PER_ALPHA(3), .MIN_FRAMES(1)) dut_b (
        .INPUT_CLK (clk),
        .RST       (rst_n),
        .TE_N      (te_n_b),
        .ADDR      (addr),
        .DATA      (data),
        .DOUT      (dout_b),
        .BUSY      (busy_b),
        .FRAME_DONE(done_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected trit of symbol sym: 0, 1 or 2 (= F).
    function automatic int exp_trit(input logic [19:0] w, input int sym);
        logic [1:0] t;
        if (sym < 8) begin
            t = w[4 + 2 * sym +: 2];
            return t[1] ? 2 : int'(t[0]);
        end
        return int'(w[sym - 8]);
    endfunction

    // Reference level at frame offset k (alpha = one clock).
    function automatic logic model_level(input logic [19:0] w, input int k);
        int t, p, h1, h2;
        if (k >= 384) return (k - 384) < 4;
        t  = exp_trit(w, k / 32);
        p  = k % 32;
        h1 = (t == 1) ? 12 : 4;
        h2 = (t == 0) ? 4 : 12;
        if (p < 16) return p < h1;
        return (p - 16) < h2;
    endfunction

    task automatic applyStimulus();
        @(negedge clk);
        te_n_a = 1'b0;
        @(negedge clk);
        te_n_a = 1'b1;
    endtask

    // Called at the negedge showing frame offset 0; leaves at offset 0 of the next frame.
    task automatic captureFrame(input string tag, input logic [19:0] w, input int chg_k,
                                input logic [15:0] chg_addr);
        int wave_err, busy_err, done_err, dec_err, nh1, nh2, p, dec;
        wave_err = 0; busy_err = 0; done_err = 0; dec_err = 0; nh1 = 0; nh2 = 0;
        for (int k = 0; k < 512; k++) begin
            p = k % 32;
            if (dout_a !== model_level(w, k)) wave_err++;
            if (busy_a !== 1'b1) busy_err++;
            if (done_a !== (k == 511)) done_err++;
            if (p == 0) begin nh1 = 0; nh2 = 0; end
            if (dout_a === 1'b1) begin
                if (p < 16) nh1++; else nh2++;
            end
            if (k < 384 && p == 31) begin
                if (nh1 == 4 && nh2 == 4) dec = 0;
                else if (nh1 == 12 && nh2 == 12) dec = 1;
                else if (nh1 == 4 && nh2 == 12) dec = 2;
                else dec = 3;
                if (dec != exp_trit(w, k / 32)) dec_err++;
            end
            if (k == chg_k) addr = chg_addr;
            @(negedge clk);
        end
        checkOutput({tag, " waveform errs"}, wave_err, 0);
        checkOutput({tag, " busy errs"}, busy_err, 0);
        checkOutput({tag, " frame_done errs"}, done_err, 0);
        checkOutput({tag, " decoded trit errs"}, dec_err, 0);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int c;
        c = 0;
        while (busy_a === 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput({tag, " busy"}, busy_a, 0);
        checkOutput({tag, " dout"}, dout_a, 0);
    endtask

    // Drops TE_N, releases it at sample cycle hold, measures the run until BUSY falls.
    task automatic measureRun(input bit sel, input int hold, input int budget,
                              output int busy_cnt, output int done_cnt,
                              output int first_high, output int drop_cycle);
        int c;
        bit in_first;
        logic d, b, f;
        busy_cnt = 0; done_cnt = 0; first_high = 0; in_first = 1'b1; c = 0;
        @(negedge clk);
        if (sel) te_n_b = 1'b0; else te_n_a = 1'b0;
        while (c < budget) begin
            @(negedge clk);
            c++;
            if (c == hold) begin
                if (sel) te_n_b = 1'b1; else te_n_a = 1'b1;
            end
            d = sel ? dout_b : dout_a;
            b = sel ? busy_b : busy_a;
            f = sel ? done_b : done_a;
            if (b === 1'b1) busy_cnt++;
            if (f === 1'b1) done_cnt++;
            if (in_first) begin
                if (d === 1'b1) first_high++; else in_first = 1'b0;
            end
            if (b !== 1'b1 && busy_cnt > 0) break;
        end
        drop_cycle = c;
        te_n_a = 1'b1;
        te_n_b = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc, dc, fh, dr, quiet_done, quiet_busy;
        checks = 0; errors = 0;
        rst_n = 1'b0; te_n_a = 1'b1; te_n_b = 1'b1; addr = 16'h0000; data = 4'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset dout_a", dout_a, 0);
        checkOutput("reset busy_a", busy_a, 0);
        checkOutput("reset done_a", done_a, 0);
        checkOutput("reset dout_b", dout_b, 0);
        checkOutput("reset busy_b", busy_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] T1 all-zero word, minimum four frames");
        addr = 16'h0000; data = 4'h0;
        applyStimulus();
        captureFrame("T1 f1", 20'h00000, -1, 16'h0);
        captureFrame("T1 f2", 20'h00000, -1, 16'h0);
        captureFrame("T1 f3", 20'h00000, -1, 16'h0);
        captureFrame("T1 f4", 20'h00000, -1, 16'h0);
        checkOutput("T1 busy after 4 frames", busy_a, 0);
        checkOutput("T1 dout after 4 frames", dout_a, 0);

        $display("[TB] T2 all-F address, data 4'hF");
        addr = 16'hAAAA; data = 4'hF;
        applyStimulus();
        captureFrame("T2 f1", {16'hAAAA, 4'hF}, -1, 16'h0);
        waitIdle("T2 idle", 3000);

        $display("[TB] T3 TE_N held low 2600 cycles");
        measureRun(1'b0, 2600, 4000, bc, dc, fh, dr);
        checkOutput("T3 busy cycles", bc, 3072);
        checkOutput("T3 frame_done count", dc, 6);
        checkOutput("T3 busy drop cycle", dr, 3073);

        $display("[TB] T4 address change mid-frame");
        addr = 16'h0000; data = 4'h0;
        @(negedge clk);
        te_n_a = 1'b0;
        @(negedge clk);
        captureFrame("T4 f1", 20'h00000, 100, 16'h5555);
        te_n_a = 1'b1;
        captureFrame("T4 f2", {16'h5555, 4'h0}, -1, 16'h0);
        waitIdle("T4 idle", 3000);

        $display("[TB] T5 reset mid-frame and restart");
        addr = 16'h6C93; data = 4'h5;
        applyStimulus();
        captureFrame("T5 f1", {16'h6C93, 4'h5}, -1, 16'h0);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("T5 dout after reset", dout_a, 0);
        checkOutput("T5 busy after reset", busy_a, 0);
        checkOutput("T5 done after reset", done_a, 0);
        rst_n = 1'b1;
        quiet_done = 0; quiet_busy = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) quiet_done++;
            if (busy_a === 1'b1) quiet_busy++;
        end
        checkOutput("T5 frame_done after reset", quiet_done, 0);
        checkOutput("T5 busy after reset idle", quiet_busy, 0);
        measureRun(1'b0, 1, 3000, bc, dc, fh, dr);
        checkOutput("T5 restart busy cycles", bc, 2048);
        checkOutput("T5 restart frame_done count", dc, 4);
        checkOutput("T5 restart busy drop cycle", dr, 2049);

        $display("[TB] T6 three clocks per alpha, single frame");
        measureRun(1'b1, 1, 3000, bc, dc, fh, dr);
        checkOutput("T6 busy cycles", bc, 1536);
        checkOutput("T6 frame_done count", dc, 1);
        checkOutput("T6 first high length", fh, 12);
        checkOutput("T6 busy drop cycle", dr, 1537);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pt2262_frame_encoder.md
Name: pt2262_frame_encoder

Overview:
- PT2262-compatible remote-control encoder.
- Clocked by the divided oscillator clock from the clock divider stage; one INPUT_CLK cycle (or CLKS_PER_ALPHA cycles) equals one oscillator period α.
- Serialises 8 tri-state address trits and 4 binary data bits into PT2262 words on DOUT, followed by a sync symbol.
- DOUT drives the RF modulator, or feeds the PT2272 decoder directly in loopback benches.

Parameters:
- CLKS_PER_ALPHA, 1: INPUT_CLK cycles per α. Legal range 1..255.
- MIN_FRAMES, 4: minimum frames sent per activation. Legal range 1..15.

Ports:
- INPUT_CLK  input  1  clock (divided oscillator clock)
- RST  input  1  synchronous, active-low reset
- TE_N  input  1  transmit enable, active low, synchronous
- ADDR  input  16  8 trits; trit i = ADDR[2i+1:2i]; 00=0, 01=1, 10=F, 11=F
- DATA  input  4  data bits D0..D3
- DOUT  output  1  encoded serial waveform, registered
- BUSY  output  1  high while a frame sequence is in progress, registered
- FRAME_DONE  output  1  one-cycle pulse on the last cycle of each sync symbol

Behaviour:
- Reset (RST=0 at posedge) has priority over everything, including mid-frame.
  - Outputs: DOUT=0, BUSY=0, FRAME_DONE=0.
  - State: IDLE; all counters cleared; latched word cleared.
- States:
  - IDLE → BIT: on the posedge where state=IDLE and TE_N=0. At that edge: latch {ADDR,DATA}, bit_idx=0, frames_sent=0. From the next cycle: BUSY=1, DOUT=1.
  - BIT (bit_idx 0..11) → SYNC after bit_idx 11.
  - SYNC → BIT (next frame) or → IDLE.
- Timing unit:
  - A prescaler counts 0..CLKS_PER_ALPHA-1; each wrap advances the α counter.
  - Bit symbol = 32α; α counter is 5 bits, wraps 31→0.
  - Sync symbol = 128α; α counter is 7 bits.
- Bit order: A0..A7 (trits from ADDR), then D0..D3 (DATA bits treated as trit 0/1).
- Bit waveforms, α counted from the symbol start:
  - 0: H4 L12 H4 L12
  - 1: H12 L4 H12 L4
  - F: H4 L12 H12 L4
- Sync waveform: H4 L124.
- Frame length = 12×32 + 128 = 512α.
- End of SYNC (last cycle):
  - FRAME_DONE=1 for that cycle; frames_sent increments, saturating at 15.
  - If TE_N=0 or frames_sent(after increment) < MIN_FRAMES: start the next frame with zero gap, re-latching ADDR/DATA at that edge.
  - Otherwise go to IDLE: next cycle BUSY=0, DOUT=0.
- TE_N released mid-frame: the current frame always completes.
- ADDR/DATA changes mid-frame have no effect; they are used only when re-latched at a frame boundary.
- TE_N is sampled only in IDLE and at the sync end.
- BUSY=1 continuously from the first DOUT high through the last sync cycle; no idle cycles between back-to-back frames.
- DOUT=0 whenever state=IDLE.

Test Plan:
- T1, CLKS_PER_ALPHA=1:
  - Stimulus: ADDR=16'h0000, DATA=0, TE_N low for 1 cycle.
  - Required: exactly 4 frames, BUSY high 2048 consecutive cycles, 4 FRAME_DONE pulses at cycles 512/1024/1536/2048 after start.
  - Required: each bit is DOUT pattern 1×4, 0×12, 1×4, 0×12; each sync is 1×4, 0×124.
- T2:
  - Stimulus: ADDR=16'hAAAA (all F), DATA=4'hF.
  - Required: bits 0..7 are H4 L12 H12 L4; bits 8..11 are H12 L4 H12 L4.
  - Required: decoded trits match when looped into the PT2272 decoder.
- T3:
  - Stimulus: TE_N held low for 2600 cycles.
  - Required: 6 frames complete (release falls inside frame 6); BUSY drops exactly 3072 cycles after start.
- T4:
  - Stimulus: change ADDR from 16'h0000 to 16'h5555 at cycle 100 of frame 1, with TE_N held low.
  - Required: frame 1 is all-0 trits; frame 2 is all-1 trits.
- T5:
  - Stimulus: RST=0 at cycle 200 of frame 2.
  - Required: next cycle DOUT=0, BUSY=0; no FRAME_DONE.
  - Required: restart after RST=1 with TE_N low begins a fresh 4-frame minimum.
- T6:
  - Stimulus: CLKS_PER_ALPHA=3, MIN_FRAMES=1, TE_N pulsed once.
  - Required: one frame of 1536 cycles; first high lasts 12 cycles; one FRAME_DONE.
